// File: rtl/swarm_pkg.sv
// ---------------------------------------------------------------------------
// swarm_pkg: shared state encoding and geometry helpers for alien_swarm.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
package swarm_pkg;

  localparam int IDX_W = 7;

  typedef enum logic [1:0] {
    ST_RIGHT   = 2'd0,
    ST_LEFT    = 2'd1,
    ST_CLEARED = 2'd2,
    ST_LANDED  = 2'd3
  } swarm_state_e;

  // Shift amount for a power-of-two cell pitch.
  function automatic int log2_pow2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) == value) n = i;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/swarm_extent.sv
// ---------------------------------------------------------------------------
// swarm_extent: leftmost/rightmost live column and lowest live row of the grid.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module swarm_extent #(
  parameter int ROWS = 4,
  parameter int COLS = 9
) (
  input  logic [ROWS*COLS-1:0] alive_i,
  output logic [3:0]           col_min_o,
  output logic [3:0]           col_max_o,
  output logic [2:0]           row_max_o,
  output logic                 any_o
);

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;

  always_comb begin
    col_any   = '0;
    row_any   = '0;
    col_min_o = '0;
    col_max_o = '0;
    row_max_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive_i[r*COLS+c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
        end
      end
    end
    // Descending scan leaves the lowest set column; ascending leaves the highest.
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_any[c]) col_min_o = 4'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (col_any[c]) col_max_o = 4'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_any[r]) row_max_o = 3'(r);
    end
    any_o = |col_any;
  end

endmodule
`default_nettype wire

// File: rtl/alien_swarm.sv
// ---------------------------------------------------------------------------
// alien_swarm: zig-zag alien formation controller with registered laser hits.
// Optional SWARM_SPEEDUP_EN: move rate rises as the number of live aliens falls.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module alien_swarm
  import swarm_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 9,
  parameter int PITCH_X = 32,
  parameter int PITCH_Y = 32,
  parameter int ALIEN_W = 24,
  parameter int ALIEN_H = 16,
  parameter int X_MIN   = 16,
  parameter int X_MAX   = 623,
  parameter int Y_LIMIT = 420,
  parameter int STEP_X  = 8,
  parameter int STEP_Y  = 16,
  parameter int START_X = 16,
  parameter int START_Y = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 laserActive,
  input  logic [9:0]           xLaser,
  input  logic [9:0]           yLaser,
  output logic [9:0]           xAlien,
  output logic [9:0]           yAlien,
  output logic [ROWS*COLS-1:0] alive,
  output logic                 killingAlien,
  output logic [IDX_W-1:0]     killIndex,
  output logic                 cleared,
  output logic                 landed
);

  localparam int NA = ROWS * COLS;
  localparam int LX = log2_pow2(PITCH_X);
  localparam int LY = log2_pow2(PITCH_Y);

  swarm_state_e     state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [NA-1:0]    alive_q, alive_d;
  logic             kill_q;
  logic [IDX_W-1:0] kidx_q, kidx_d;

  logic [3:0] col_min, col_max;
  logic [2:0] row_max;
  logic       any_alive;

  swarm_extent #(.ROWS(ROWS), .COLS(COLS)) u_extent (
    .alive_i   (alive_q),
    .col_min_o (col_min),
    .col_max_o (col_max),
    .row_max_o (row_max),
    .any_o     (any_alive)
  );

  logic [10:0] left_edge, right_edge, y_step, bottom_step;
  assign left_edge   = {1'b0, x_q} + (11'(col_min) << LX);
  assign right_edge  = {1'b0, x_q} + (11'(col_max) << LX) + 11'(ALIEN_W - 1);
  assign y_step      = {1'b0, y_q} + 11'(STEP_Y);
  assign bottom_step = y_step + (11'(row_max) << LY) + 11'(ALIEN_H - 1);

  // Laser position relative to the formation origin; bit 10 is the sign.
  logic [10:0]      rel_x, rel_y, cell_c, cell_r;
  logic [IDX_W-1:0] hit_idx;
  logic [NA-1:0]    hit_sel;
  logic             hit;
  assign rel_x   = {1'b0, xLaser} - {1'b0, x_q};
  assign rel_y   = {1'b0, yLaser} - {1'b0, y_q};
  assign cell_c  = rel_x >> LX;
  assign cell_r  = rel_y >> LY;
  assign hit_idx = IDX_W'(cell_r * 11'(COLS) + cell_c);
  assign hit_sel = NA'(1) << hit_idx;
  assign hit = laserActive && !rel_x[10] && !rel_y[10]
            && (cell_c < 11'(COLS)) && (cell_r < 11'(ROWS))
            && ((rel_x & 11'(PITCH_X - 1)) < 11'(ALIEN_W))
            && ((rel_y & 11'(PITCH_Y - 1)) < 11'(ALIEN_H))
            && (|(alive_q & hit_sel)) && (state_q != ST_CLEARED);

  logic move;
`ifdef SWARM_SPEEDUP_EN
  logic [5:0] cnt_q, cnt_d, pace;
  logic [7:0] pop;
  always_comb begin
    pop = '0;
    for (int i = 0; i < NA; i++) pop = pop + 8'(alive_q[i]);
  end
  assign pace = 6'(pop >> 2);
  assign move = tick && (cnt_q >= pace);
  always_comb begin
    cnt_d = cnt_q;
    if (move)      cnt_d = '0;
    else if (tick) cnt_d = cnt_q + 6'd1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign move = tick;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    alive_d = alive_q;
    kidx_d  = kidx_q;
    if (hit) begin
      alive_d = alive_q & ~hit_sel;
      kidx_d  = hit_idx;
    end
    case (state_q)
      ST_RIGHT, ST_LEFT: begin
        if (!any_alive) begin
          state_d = ST_CLEARED;
        end else if (move) begin
          if (state_q == ST_RIGHT) begin
            if (right_edge + 11'(STEP_X) > 11'(X_MAX)) begin
              y_d     = y_step[9:0];
              state_d = (bottom_step > 11'(Y_LIMIT)) ? ST_LANDED : ST_LEFT;
            end else begin
              x_d = x_q + 10'(STEP_X);
            end
          end else begin
            if (left_edge < 11'(X_MIN + STEP_X)) begin
              y_d     = y_step[9:0];
              state_d = (bottom_step > 11'(Y_LIMIT)) ? ST_LANDED : ST_RIGHT;
            end else begin
              x_d = x_q - 10'(STEP_X);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RIGHT;
      x_q     <= 10'(START_X);
      y_q     <= 10'(START_Y);
      alive_q <= '1;
      kill_q  <= 1'b0;
      kidx_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      alive_q <= alive_d;
      kill_q  <= hit;
      kidx_q  <= kidx_d;
    end
  end

  assign xAlien       = x_q;
  assign yAlien       = y_q;
  assign alive        = alive_q;
  assign killingAlien = kill_q;
  assign killIndex    = kidx_q;
  assign cleared      = (state_q == ST_CLEARED);
  assign landed       = (state_q == ST_LANDED);

endmodule
`default_nettype wire

// File: tb/tb_alien_swarm.sv
// ---------------------------------------------------------------------------
// tb_alien_swarm: directed self-checking bench for alien_swarm (default build).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps
module tb_alien_swarm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        laserActive = 1'b0;
  logic [9:0]  xLaser = '0;
  logic [9:0]  yLaser = '0;
  logic [9:0]  xAlien, yAlien;
  logic [35:0] alive;
  logic        killingAlien;
  logic [6:0]  killIndex;
  logic        cleared, landed;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] exp_alive;

  always #5 clk = ~clk;

  alien_swarm dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .laserActive  (laserActive),
    .xLaser       (xLaser),
    .yLaser       (yLaser),
    .xAlien       (xAlien),
    .yAlien       (yAlien),
    .alive        (alive),
    .killingAlien (killingAlien),
    .killIndex    (killIndex),
    .cleared      (cleared),
    .landed       (landed)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  task automatic aim(input int x, input int y);
    xLaser = 10'(x);
    yLaser = 10'(y);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_cmp++; if (xAlien !== 10'd16) begin n_err++; $display("FAIL reset_x: got %0d expected 16", xAlien); end
    n_cmp++; if (yAlien !== 10'd40) begin n_err++; $display("FAIL reset_y: got %0d expected 40", yAlien); end
    n_cmp++; if (alive !== {36{1'b1}}) begin n_err++; $display("FAIL reset_alive: got %h expected fffffffff", alive); end
    n_cmp++; if ({killingAlien, killIndex, cleared, landed} !== 10'd0) begin
      n_err++; $display("FAIL reset_flags: got kill=%b idx=%0d clr=%b land=%b expected all 0", killingAlien, killIndex, cleared, landed);
    end
    reset = 1'b1;
  endtask

  task automatic test_move_right();
    do_ticks(1);
    n_cmp++; if (xAlien !== 10'd24 || yAlien !== 10'd40) begin n_err++; $display("FAIL move_right: got (%0d,%0d) expected (24,40)", xAlien, yAlien); end
    n_cmp++; if (alive !== {36{1'b1}}) begin n_err++; $display("FAIL move_alive: got %h expected fffffffff", alive); end
  endtask

  task automatic test_edge_turn();
    do_ticks(40);
    n_cmp++; if (xAlien !== 10'd344 || yAlien !== 10'd40) begin n_err++; $display("FAIL pre_edge: got (%0d,%0d) expected (344,40)", xAlien, yAlien); end
    do_ticks(1);
    n_cmp++; if (xAlien !== 10'd344 || yAlien !== 10'd56) begin n_err++; $display("FAIL edge_turn: got (%0d,%0d) expected (344,56)", xAlien, yAlien); end
    do_ticks(1);
    n_cmp++; if (xAlien !== 10'd336 || yAlien !== 10'd56) begin n_err++; $display("FAIL move_left: got (%0d,%0d) expected (336,56)", xAlien, yAlien); end
  endtask

  task automatic test_hit();
    int pulses;
    aim(336 + 3*32 + 5, 56 + 32 + 3);
    laserActive = 1'b1;
    step();
    exp_alive = {36{1'b1}};
    exp_alive[12] = 1'b0;
    n_cmp++; if (killingAlien !== 1'b1 || killIndex !== 7'd12) begin n_err++; $display("FAIL hit_pulse: got kill=%b idx=%0d expected kill=1 idx=12", killingAlien, killIndex); end
    n_cmp++; if (alive !== exp_alive) begin n_err++; $display("FAIL hit_alive: got %h expected %h", alive, exp_alive); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (killingAlien) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL hit_no_double: got %0d extra pulses expected 0", pulses); end
    laserActive = 1'b0;
  endtask

  task automatic test_gap();
    int pulses;
    pulses = 0;
    aim(336 + 28, 56 + 2);
    laserActive = 1'b1;
    step();
    if (killingAlien) pulses++;
    aim(336 + 2, 56 + 20);
    step();
    if (killingAlien) pulses++;
    step();
    if (killingAlien) pulses++;
    laserActive = 1'b0;
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL gap_pulse: got %0d pulses expected 0", pulses); end
    n_cmp++; if (alive !== exp_alive) begin n_err++; $display("FAIL gap_alive: got %h expected %h", alive, exp_alive); end
  endtask

  task automatic test_column_edge();
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = 8 + 9*k;
      aim(336 + (idx % 9)*32 + 2, 56 + (idx / 9)*32 + 2);
      laserActive = 1'b1;
      step();
      n_cmp++; if (killingAlien !== 1'b1 || killIndex !== 7'(idx)) begin n_err++; $display("FAIL col_kill: got kill=%b idx=%0d expected kill=1 idx=%0d", killingAlien, killIndex, idx); end
      laserActive = 1'b0;
      exp_alive[idx] = 1'b0;
      step();
    end
    n_cmp++; if (alive !== exp_alive) begin n_err++; $display("FAIL col_alive: got %h expected %h", alive, exp_alive); end
    do_ticks(40);
    n_cmp++; if (xAlien !== 10'd16 || yAlien !== 10'd56) begin n_err++; $display("FAIL left_end: got (%0d,%0d) expected (16,56)", xAlien, yAlien); end
    do_ticks(1);
    n_cmp++; if (xAlien !== 10'd16 || yAlien !== 10'd72) begin n_err++; $display("FAIL left_turn: got (%0d,%0d) expected (16,72)", xAlien, yAlien); end
    do_ticks(45);
    n_cmp++; if (xAlien !== 10'd376 || yAlien !== 10'd72) begin n_err++; $display("FAIL narrow_pre: got (%0d,%0d) expected (376,72)", xAlien, yAlien); end
    do_ticks(1);
    n_cmp++; if (xAlien !== 10'd376 || yAlien !== 10'd88) begin n_err++; $display("FAIL narrow_turn: got (%0d,%0d) expected (376,88)", xAlien, yAlien); end
    do_ticks(1);
    n_cmp++; if (xAlien !== 10'd368 || yAlien !== 10'd88) begin n_err++; $display("FAIL narrow_left: got (%0d,%0d) expected (368,88)", xAlien, yAlien); end
  endtask

  task automatic test_clear();
    reset = 1'b0;
    step();
    reset = 1'b1;
    // Tick and kill of alien 0 share one edge.
    aim(16 + 2, 40 + 2);
    laserActive = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_cmp++; if (xAlien !== 10'd24 || killingAlien !== 1'b1 || killIndex !== 7'd0 || alive[0] !== 1'b0) begin
      n_err++; $display("FAIL tick_and_kill: got x=%0d kill=%b idx=%0d a0=%b expected x=24 kill=1 idx=0 a0=0", xAlien, killingAlien, killIndex, alive[0]);
    end
    for (int idx = 1; idx < 36; idx++) begin
      aim(24 + (idx % 9)*32 + 2, 40 + (idx / 9)*32 + 2);
      step();
      n_cmp++; if (killingAlien !== 1'b1 || killIndex !== 7'(idx)) begin n_err++; $display("FAIL clear_kill: got kill=%b idx=%0d expected kill=1 idx=%0d", killingAlien, killIndex, idx); end
    end
    n_cmp++; if (alive !== 36'd0 || cleared !== 1'b0) begin n_err++; $display("FAIL last_kill: got alive=%h clr=%b expected alive=0 clr=0", alive, cleared); end
    laserActive = 1'b0;
    step();
    n_cmp++; if (cleared !== 1'b1 || killingAlien !== 1'b0) begin n_err++; $display("FAIL cleared: got clr=%b kill=%b expected clr=1 kill=0", cleared, killingAlien); end
    do_ticks(5);
    n_cmp++; if (xAlien !== 10'd24 || yAlien !== 10'd40 || cleared !== 1'b1) begin n_err++; $display("FAIL cleared_frozen: got (%0d,%0d) clr=%b expected (24,40) clr=1", xAlien, yAlien, cleared); end
  endtask

  task automatic test_landing();
    reset = 1'b0;
    step();
    reset = 1'b1;
    do_ticks(713);
    n_cmp++; if (xAlien !== 10'd344 || yAlien !== 10'd296 || landed !== 1'b0) begin n_err++; $display("FAIL pre_land: got (%0d,%0d) land=%b expected (344,296) land=0", xAlien, yAlien, landed); end
    do_ticks(1);
    n_cmp++; if (xAlien !== 10'd344 || yAlien !== 10'd312 || landed !== 1'b1) begin n_err++; $display("FAIL landed: got (%0d,%0d) land=%b expected (344,312) land=1", xAlien, yAlien, landed); end
    do_ticks(3);
    n_cmp++; if (xAlien !== 10'd344 || yAlien !== 10'd312) begin n_err++; $display("FAIL land_frozen: got (%0d,%0d) expected (344,312)", xAlien, yAlien); end
    aim(344 + 2, 312 + 2);
    laserActive = 1'b1;
    step();
    laserActive = 1'b0;
    n_cmp++; if (killingAlien !== 1'b1 || alive[0] !== 1'b0 || landed !== 1'b1) begin n_err++; $display("FAIL land_kill: got kill=%b a0=%b land=%b expected kill=1 a0=0 land=1", killingAlien, alive[0], landed); end
    // Reset asserted between edges must act immediately.
    @(posedge clk);
    #2;
    tick = 1'b1;
    reset = 1'b0;
    #1;
    n_cmp++; if (xAlien !== 10'd16 || yAlien !== 10'd40 || landed !== 1'b0 || alive !== {36{1'b1}}) begin
      n_err++; $display("FAIL async_reset: got (%0d,%0d) land=%b alive=%h expected (16,40) land=0 alive=fffffffff", xAlien, yAlien, landed, alive);
    end
    step();
    reset = 1'b1;
    tick = 1'b0;
    n_cmp++; if (xAlien !== 10'd16 || killingAlien !== 1'b0) begin n_err++; $display("FAIL reset_hold: got x=%0d kill=%b expected x=16 kill=0", xAlien, killingAlien); end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_edge_turn();
    test_hit();
    test_gap();
    test_column_edge();
    test_clear();
    test_landing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alien_swarm.md
Name: alien_swarm

Overview:
Parametrised alien-formation controller: a ROWS x COLS grid of aliens with an alive bitmap.
- Moves the formation in a zig-zag (horizontal steps, step down at the play-field edges), using the edges of the alive columns and rows.
- Detects laser hits and reports formation state.
- Sits between the motion/laser time-unit enables and the alien colour renderer; supplies xAlien/yAlien/alive to it and killingAlien to the laser.

Parameters:
ROWS, 4, formation rows (1..8)
COLS, 9, formation columns (1..16)
PITCH_X, 32, horizontal cell pitch in pixels; power of two
PITCH_Y, 32, vertical cell pitch in pixels; power of two
ALIEN_W, 24, alien sprite width (< PITCH_X)
ALIEN_H, 16, alien sprite height (< PITCH_Y)
X_MIN, 16, leftmost pixel the formation may occupy
X_MAX, 623, rightmost pixel the formation may occupy
Y_LIMIT, 420, bottom pixel; crossing it means the aliens have landed
STEP_X, 8, horizontal step per move
STEP_Y, 16, vertical step at an edge
START_X, 16, reset origin x
START_Y, 40, reset origin y

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle motion enable pulse
laserActive  in  1  laser is in flight
xLaser  in  10  laser tip x
yLaser  in  10  laser tip y
xAlien  out  10  formation origin x (top-left of cell 0,0)
yAlien  out  10  formation origin y
alive  out  ROWS*COLS  alive bitmap; bit r*COLS+c
killingAlien  out  1  one-cycle pulse on a hit
killIndex  out  7  index of the last killed alien
cleared  out  1  all aliens dead (sticky)
landed  out  1  formation crossed Y_LIMIT (sticky)

Behaviour:
- Reset (reset low, async):
  - xAlien=START_X, yAlien=START_Y, alive all ones.
  - killingAlien=0, killIndex=0, cleared=0, landed=0.
  - State RIGHT.
- States:
  - RIGHT, LEFT: moving.
  - CLEARED, LANDED: terminal; stay there until reset.
- Edges, from the current alive bitmap:
  - colMin/colMax = lowest/highest column with any alive bit; rowMax = highest row with any alive bit.
  - leftEdge = xAlien + colMin*PITCH_X.
  - rightEdge = xAlien + colMax*PITCH_X + ALIEN_W - 1.
  - bottom = yAlien + rowMax*PITCH_Y + ALIEN_H - 1.
- On tick in RIGHT:
  - if rightEdge+STEP_X > X_MAX: yAlien += STEP_Y and go to LEFT; x is unchanged.
  - else xAlien += STEP_X.
- On tick in LEFT:
  - if leftEdge < X_MIN+STEP_X: yAlien += STEP_Y and go to RIGHT.
  - else xAlien -= STEP_X.
- Motion arithmetic is 11-bit internally, so no wrap-around occurs.
- Landing: after any vertical step, if the new bottom > Y_LIMIT, go to LANDED and set landed=1 on the same edge. Position then freezes.
- Hit detection, registered:
  - relX = xLaser - xAlien and relY = yLaser - yAlien, both signed 11-bit.
  - A hit requires relX, relY >= 0; c = relX/PITCH_X < COLS; r = relY/PITCH_Y < ROWS.
  - It also requires relX mod PITCH_X < ALIEN_W, relY mod PITCH_Y < ALIEN_H, alive[r*COLS+c]=1 and laserActive=1.
  - Outcome: on the next edge, clear that alive bit, set killIndex = r*COLS+c, and pulse killingAlien for exactly 1 cycle. Latency is 1 clk.
- The cleared alive bit prevents a double kill if laserActive stays high.
- At most one kill per cycle.
- Hits are still detected in LANDED but ignored in CLEARED.
- When the alive bitmap becomes zero, go to CLEARED and set cleared=1 on the edge after the last kill. Motion stops.
- Simultaneous tick and hit: both use registered pre-edge values; the move and the kill commit on the same edge. Edges for that move use the pre-kill bitmap.
- tick with no alive aliens is ignored.

Optional Feature:
SWARM_SPEEDUP_EN
- Defined:
  - An internal tick counter counts up to N = popcount(alive) >> 2 before a move occurs; the move occurs on the tick that reaches N, then the counter resets.
  - With N=0, the formation moves on every tick.
  - Fewer aliens means faster motion.
  - The counter clears on reset and on every move.
- Undefined: the formation moves on every tick; no counter or popcount logic is present.

Decomposition:
- Package swarm_pkg holds:
  - state enum (RIGHT, LEFT, CLEARED, LANDED);
  - localparam log2 helpers for PITCH_X/PITCH_Y;
  - index width constant (7).
- One sub-module, swarm_extent: purely combinational. It takes the alive bitmap and outputs colMin, colMax, rowMax and an any-alive flag (priority encoders over OR-reduced columns/rows). It is instantiated once.

Test Plan:
- Reset then 1 tick -> xAlien 16->24, yAlien 40, state RIGHT, alive all ones.
- Ticks until rightEdge+8 > 623 (default geometry: xAlien=344, rightEdge=623) -> next tick gives yAlien=56, xAlien=344, state LEFT; following tick gives xAlien=336.
- Laser at (START_X+3*32+5, START_Y+1*32+3), laserActive=1 -> one cycle later killingAlien=1 for 1 cycle, killIndex=12, alive[12]=0. Holding the laser there 5 more cycles gives no further pulse.
- Kill all of column 8 (indices 8,17,26,35), then run right -> the edge turn happens at xAlien=376 instead of 344. Laser in the gap (relX mod 32 = 28) gives no hit.
- Kill all 36 aliens -> cleared=1 one cycle after the last kill; further ticks leave xAlien/yAlien unchanged.
- Drive the formation down until bottom > 420 -> landed=1 and position frozen. Asserting reset low asynchronously mid-move gives immediate START values.
